qed_dup_unit: RTL and testbench

Parametrised QED instruction-duplication unit between instruction fetch and the if_id register. It passes original instructions through to decode while recording them in an internal FIFO, then replays each one transformed (register indices shifted into the duplicate half of the register file, memory offsets shifted into the duplicate memory region) so the core executes an EDDI-V original/duplicate sequence. Unlike the single-mode qed block, it is generalised in FIFO depth, register/memory offsets, and transform policy, and it supports self-triggered replay on FIFO full and a bypass mode.

---
 rtl/qed_dup_unit_pkg.sv | 37 +++
 rtl/qed_dup_unit_if.sv | 31 +++
 rtl/qed_dup_unit_xform.sv | 63 ++++++
 rtl/qed_dup_unit.sv | 109 ++++++++++
 tb/tb_qed_dup_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/qed_dup_unit_pkg.sv
// Shared opcodes, field positions, state encoding and helpers for the
// QED duplication unit.
package qed_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    localparam int unsigned OPC_LSB   = 0;
    localparam int unsigned RD_LSB    = 7;
    localparam int unsigned RS1_LSB   = 15;
    localparam int unsigned RS2_LSB   = 20;
    localparam int unsigned IMM_I_LSB = 20;
    localparam int unsigned IMM_SH_LSB = 25;
    localparam int unsigned IMM_SL_LSB = 7;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic {
        ORIG = 1'b0,
        DUP  = 1'b1
    } state_t;

    // x0 is hard-wired, so it must stay x0 in the duplicate stream.
    function automatic logic [4:0] remap_reg(input logic [4:0] r, input logic [4:0] off);
        return (r == 5'd0) ? r : r + off;
    endfunction

endpackage

// File: rtl/qed_dup_unit_if.sv
// Fetch-side and decode-side signal bundle of the QED duplication unit.
interface qed_dup_unit_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              ena;
    logic [31:0]       ifu_instruction_i;
    logic              ifu_vld_i;
    logic              stall_IF_i;
    logic              exec_dup_i;
    logic              ifu_ready_o;
    logic [31:0]       qed_instruction_o;
    logic              vld_out_o;
    logic              dup_active_o;
    logic [CNT_W-1:0]  count_o;
    logic              nop_subst_o;

    modport slave (
        input  ena, ifu_instruction_i, ifu_vld_i, stall_IF_i, exec_dup_i,
        output ifu_ready_o, qed_instruction_o, vld_out_o, dup_active_o,
               count_o, nop_subst_o
    );

    modport master (
        output ena, ifu_instruction_i, ifu_vld_i, stall_IF_i, exec_dup_i,
        input  ifu_ready_o, qed_instruction_o, vld_out_o, dup_active_o,
               count_o, nop_subst_o
    );

endinterface

// File: rtl/qed_dup_unit_xform.sv
// Combinational EDDI-V transform: shifts register indices into the duplicate
// register half and memory offsets into the duplicate region.
module qed_xform
    import qed_pkg::*;
#(
    parameter int unsigned REG_OFFSET = 16,
    parameter logic [11:0] MEM_OFFSET = 12'h400,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic [31:0] inst,
    output logic [31:0] inst_out,
    output logic        nop
);

    localparam logic [4:0] ROFF = 5'(REG_OFFSET);

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm_i, imm_s;

    assign opcode = inst[OPC_LSB +: 7];
    assign rd     = inst[RD_LSB +: 5];
    assign rs1    = inst[RS1_LSB +: 5];
    assign rs2    = inst[RS2_LSB +: 5];
    assign imm_i  = inst[IMM_I_LSB +: 12] + MEM_OFFSET;
    assign imm_s  = {inst[IMM_SH_LSB +: 7], inst[IMM_SL_LSB +: 5]} + MEM_OFFSET;

    always_comb begin
        inst_out = inst;
        nop      = 1'b0;
        case (opcode)
            OP: begin
                inst_out[RD_LSB +: 5]  = remap_reg(rd, ROFF);
                inst_out[RS1_LSB +: 5] = remap_reg(rs1, ROFF);
                inst_out[RS2_LSB +: 5] = remap_reg(rs2, ROFF);
            end
            OP_IMM: begin
                inst_out[RD_LSB +: 5]  = remap_reg(rd, ROFF);
                inst_out[RS1_LSB +: 5] = remap_reg(rs1, ROFF);
            end
            LOAD: begin
                inst_out[RD_LSB +: 5]     = remap_reg(rd, ROFF);
                inst_out[RS1_LSB +: 5]    = remap_reg(rs1, ROFF);
                inst_out[IMM_I_LSB +: 12] = imm_i;
            end
            STORE: begin
                inst_out[RS1_LSB +: 5]    = remap_reg(rs1, ROFF);
                inst_out[RS2_LSB +: 5]    = remap_reg(rs2, ROFF);
                inst_out[IMM_SH_LSB +: 7] = imm_s[11:5];
                inst_out[IMM_SL_LSB +: 5] = imm_s[4:0];
            end
            LUI, AUIPC: begin
                inst_out[RD_LSB +: 5] = remap_reg(rd, ROFF);
            end
            // Control flow, system, fence and unknown opcodes are not replayed.
            default: begin
                inst_out = NOP_INST;
                nop      = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/qed_dup_unit.sv
// QED instruction-duplication unit: passes originals to decode while queueing
// them, then replays the transformed duplicates from an inline FIFO.
module qed_dup_unit
    import qed_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned REG_OFFSET = 16,
    parameter logic [11:0] MEM_OFFSET = 12'h400,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    qed_dup_unit_if.slave   bus
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    state_t            state;
    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, post_count;
    logic [31:0]       qed_inst;
    logic              vld_out, dup_active, nop_subst;
    logic              adv, push, go_dup;
    logic [31:0]       x_inst;
    logic              x_nop;

    assign adv  = ~bus.stall_IF_i;
    assign push = adv & (state == ORIG) & bus.ena & bus.ifu_vld_i;
    assign post_count = count + CNT_W'(push);

    // Full-trigger and exec_dup collapse into one transition on the same edge.
    assign go_dup = adv & (state == ORIG) & bus.ena &
                    ((bus.exec_dup_i & (post_count != '0)) |
                     (post_count == CNT_W'(DEPTH)));

    qed_xform #(
        .REG_OFFSET (REG_OFFSET),
        .MEM_OFFSET (MEM_OFFSET),
        .NOP_INST   (NOP_INST)
    ) u_xform (
        .inst     (mem[rd_ptr]),
        .inst_out (x_inst),
        .nop      (x_nop)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.ifu_instruction_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ORIG;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            qed_inst   <= NOP_INST;
            vld_out    <= 1'b0;
            dup_active <= 1'b0;
            nop_subst  <= 1'b0;
        end else if (adv) begin
            case (state)
                ORIG: begin
                    nop_subst <= 1'b0;
                    vld_out   <= bus.ifu_vld_i;
                    if (bus.ena) begin
                        if (push) begin
                            qed_inst <= bus.ifu_instruction_i;
                            wr_ptr   <= wr_ptr + 1'b1;
                        end
                        count <= post_count;
                        if (go_dup) begin
                            state      <= DUP;
                            dup_active <= 1'b1;
                        end
                    end else begin
                        qed_inst <= bus.ifu_instruction_i;
                    end
                end
                DUP: begin
                    qed_inst  <= x_inst;
                    nop_subst <= x_nop;
                    vld_out   <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                    count     <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state      <= ORIG;
                        dup_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= ORIG;
                    dup_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_ready_o       = adv & (state == ORIG);
    assign bus.qed_instruction_o = qed_inst;
    assign bus.vld_out_o         = vld_out;
    assign bus.dup_active_o      = dup_active;
    assign bus.count_o           = count;
    assign bus.nop_subst_o       = nop_subst;

endmodule

// File: tb/tb_qed_dup_unit.sv
// Directed self-checking bench for qed_dup_unit with hand-computed vectors.
module tb_qed_dup_unit;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    qed_dup_unit_if #(.DEPTH(DEPTH)) bus ();

    qed_dup_unit #(
        .DEPTH      (DEPTH),
        .REG_OFFSET (16),
        .MEM_OFFSET (12'h400),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] inst, input logic vld,
                             input logic dup, input logic [3:0] cnt, input logic nop);
        check({tag, "_inst"}, bus.qed_instruction_o, inst);
        check({tag, "_vld"},  32'(bus.vld_out_o),    32'(vld));
        check({tag, "_dup"},  32'(bus.dup_active_o), 32'(dup));
        check({tag, "_cnt"},  32'(bus.count_o),      32'(cnt));
        check({tag, "_nop"},  32'(bus.nop_subst_o),  32'(nop));
    endtask

    // addi xk,xk,k and its duplicate addi x(k+16),x(k+16),k
    function automatic logic [31:0] addi_k(input int unsigned k);
        return (32'(k) << 20) | (32'(k) << 15) | (32'(k) << 7) | 32'h13;
    endfunction
    function automatic logic [31:0] addi_dup(input int unsigned k);
        return (32'(k) << 20) | (32'(k + 16) << 15) | (32'(k + 16) << 7) | 32'h13;
    endfunction

    task automatic push(input logic [31:0] inst, input logic exec);
        bus.ifu_vld_i         = 1'b1;
        bus.ifu_instruction_i = inst;
        bus.exec_dup_i        = exec;
        step();
        bus.ifu_vld_i  = 1'b0;
        bus.exec_dup_i = 1'b0;
    endtask

    initial begin
        bus.ena               = 1'b1;
        bus.ifu_instruction_i = '0;
        bus.ifu_vld_i         = 1'b0;
        bus.stall_IF_i        = 1'b0;
        bus.exec_dup_i        = 1'b0;
        #12 rst = 1'b0;
        #1;

        check_out("reset", 32'h13, 1'b0, 1'b0, 4'd0, 1'b0);
        check("reset_ready", 32'(bus.ifu_ready_o), 32'd1);

        // Basic replay: original passes through, duplicate follows
        push(32'h0020_81B3, 1'b1);
        check_out("add_orig", 32'h0020_81B3, 1'b1, 1'b1, 4'd1, 1'b0);
        check("add_ready_dup", 32'(bus.ifu_ready_o), 32'd0);
        step();
        check_out("add_dup", 32'h0128_89B3, 1'b1, 1'b0, 4'd0, 1'b0);
        step();
        check("idle_vld", 32'(bus.vld_out_o), 32'd0);

        // exec_dup with empty FIFO and no push does nothing
        bus.exec_dup_i = 1'b1;
        step();
        bus.exec_dup_i = 1'b0;
        check("empty_exec_dup", 32'(bus.dup_active_o), 32'd0);

        // Memory offsets
        push(32'h0081_2283, 1'b1);
        check_out("lw_orig", 32'h0081_2283, 1'b1, 1'b1, 4'd1, 1'b0);
        step();
        check_out("lw_dup", 32'h4089_2A83, 1'b1, 1'b0, 4'd0, 1'b0);
        push(32'h0051_2223, 1'b1);
        check("sw_orig", bus.qed_instruction_o, 32'h0051_2223);
        step();
        check_out("sw_dup", 32'h4159_2223, 1'b1, 1'b0, 4'd0, 1'b0);

        // Full trigger without exec_dup
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            check("full_ready_orig", 32'(bus.ifu_ready_o), 32'd1);
            push(addi_k(k), 1'b0);
            check_out("full_push", addi_k(k), 1'b1, k == DEPTH, 4'(k), 1'b0);
        end
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            // fetch traffic during replay must be ignored
            bus.ifu_vld_i         = 1'b1;
            bus.ifu_instruction_i = 32'h0000_0033;
            check("full_ready_dup", 32'(bus.ifu_ready_o), 32'd0);
            step();
            check_out("full_pop", addi_dup(k), 1'b1, k != DEPTH, 4'(DEPTH - k), 1'b0);
        end
        bus.ifu_vld_i = 1'b0;
        step();
        check("full_after", 32'(bus.count_o), 32'd0);

        // Stall mid-replay
        for (int unsigned k = 9; k <= 12; k++) push(addi_k(k), k == 12);
        check("stall_cnt4", 32'(bus.count_o), 32'd4);
        step();
        check_out("stall_pop1", addi_dup(9), 1'b1, 1'b1, 4'd3, 1'b0);
        bus.stall_IF_i = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            check("stall_ready", 32'(bus.ifu_ready_o), 32'd0);
            step();
            check_out("stall_hold", addi_dup(9), 1'b1, 1'b1, 4'd3, 1'b0);
        end
        bus.stall_IF_i = 1'b0;
        for (int unsigned k = 10; k <= 12; k++) begin
            step();
            check_out("stall_resume", addi_dup(k), 1'b1, k != 12, 4'(12 - k), 1'b0);
        end

        // Substitution of control flow
        push(32'h0000_0063, 1'b1);
        check_out("beq_orig", 32'h0000_0063, 1'b1, 1'b1, 4'd1, 1'b0);
        step();
        check_out("beq_dup", 32'h0000_0013, 1'b1, 1'b0, 4'd0, 1'b1);
        step();
        check("nop_pulse_end", 32'(bus.nop_subst_o), 32'd0);

        // Bypass
        bus.ena = 1'b0;
        push(32'h0000_0033, 1'b1);
        check_out("bypass", 32'h0000_0033, 1'b1, 1'b0, 4'd0, 1'b0);
        bus.ifu_instruction_i = 32'h0000_0033;
        step();
        check("bypass_novld", 32'(bus.vld_out_o), 32'd0);
        bus.ena = 1'b1;

        // Reset mid-replay
        for (int unsigned k = 1; k <= 3; k++) push(addi_k(k), k == 3);
        check("rst_pre_cnt", 32'(bus.count_o), 32'd3);
        check("rst_pre_dup", 32'(bus.dup_active_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_out("rst_async", 32'h13, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_out("rst_after", 32'h13, 1'b0, 1'b0, 4'd0, 1'b0);
        check("rst_ready", 32'(bus.ifu_ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
